// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receive FIFO to its consumer.
// First-word fall-through valid/ready handshake.
interface uart_rx_fifo_if #(
  parameter int W_DATA = 8
);
  logic              m_valid;
  logic [W_DATA-1:0] m_data;
  logic              m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-detected push, FWFT pop.
// Optional UART_RX_FIFO_ALMOST_FULL_EN adds a registered almost_full.
module uart_rx_fifo #(
  parameter int W_DATA   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   rx_data_valid,
  input  logic [W_DATA-1:0]      rx_data,
  uart_rx_fifo_if.master         m_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                   almost_full
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam bit CFG_OK =
    (DEPTH >= 2) &&
    ((DEPTH & (DEPTH - 1)) == 0) &&
    (AF_LEVEL >= 0) && (AF_LEVEL <= DEPTH);

  if (!CFG_OK) begin : g_bad_cfg
    $error("uart_rx_fifo: bad DEPTH/AF_LEVEL");
  end

  logic [W_DATA-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          vld_q, vld_d;
  logic          overflow_q, overflow_d;

  logic full;
  logic not_empty;
  logic push;
  logic pop;
  logic accept;
  logic drop;

  always_comb begin
    full       = (count_q == FULL_C);
    not_empty  = (count_q != '0);
    push       = rx_data_valid & ~vld_q;
    pop        = not_empty & m_if.m_ready;
    // a pop on a full FIFO frees the slot the push lands in
    accept     = push & (~full | pop);
    drop       = push & full & ~pop;
    vld_d      = rx_data_valid;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = drop | (overflow_q & ~clr_ovf);
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case (1'b1)
      accept & ~pop: count_d = count_q + CW'(1);
      pop & ~accept: count_d = count_q - CW'(1);
      default:       count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vld_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // head is forced to zero when empty so reset shows a clean bus
  assign m_if.m_valid = not_empty;
  assign m_if.m_data  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign count        = count_q;
  assign overflow     = overflow_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);

  logic af_q, af_d;

  always_comb begin
    af_d = (count_d >= AF_C);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus corner sequences.
// Define UART_RX_FIFO_ALMOST_FULL_EN to also cover almost_full.
module tb_uart_rx_fifo;

  logic       clk;
  logic       arstn;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic [4:0] count;
  logic       overflow;
  logic       clr_ovf;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int n_cmp;
  int n_bad;

  uart_rx_fifo_if #(.W_DATA(8)) s_if ();

  uart_rx_fifo #(
    .W_DATA  (8),
    .DEPTH   (16),
    .AF_LEVEL(12)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .rx_data_valid(rx_data_valid),
    .rx_data      (rx_data),
    .m_if         (s_if.master),
    .count        (count),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full  (almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] n;
    logic       dv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       eo;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] d,
                      input logic rdy, input logic clr);
    rx_data_valid = dv;
    rx_data       = d;
    s_if.m_ready  = rdy;
    clr_ovf       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rdy);
    step(1'b0, b, rdy, 1'b0);
    step(1'b1, b, rdy, 1'b0);
  endtask

  task automatic chk_state(input string nm, input logic v,
                           input logic [7:0] d, input int c,
                           input logic o);
    chk({nm, ".valid"}, int'(s_if.m_valid), int'(v));
    chk({nm, ".data"},  int'(s_if.m_data),  int'(d));
    chk({nm, ".count"}, int'(count),        c);
    chk({nm, ".ovf"},   int'(overflow),     int'(o));
  endtask

  initial begin
    int got;
    n_cmp = 0;
    n_bad = 0;

    //     n    dv  d     rdy clr  ev  ed     ec  eo
    tbl[0]  = '{8'd20, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b0, 8'h00, 5'd0, 1'b0};
    tbl[1]  = '{8'd10, 1'b0, 8'h00, 1'b0, 1'b0,
                1'b0, 8'h00, 5'd0, 1'b0};
    tbl[2]  = '{8'd1,  1'b1, 8'h41, 1'b0, 1'b0,
                1'b1, 8'h41, 5'd1, 1'b0};
    tbl[3]  = '{8'd10, 1'b0, 8'h41, 1'b0, 1'b0,
                1'b1, 8'h41, 5'd1, 1'b0};
    tbl[4]  = '{8'd1,  1'b1, 8'h42, 1'b0, 1'b0,
                1'b1, 8'h41, 5'd2, 1'b0};
    tbl[5]  = '{8'd10, 1'b0, 8'h42, 1'b0, 1'b0,
                1'b1, 8'h41, 5'd2, 1'b0};
    tbl[6]  = '{8'd1,  1'b1, 8'h43, 1'b0, 1'b0,
                1'b1, 8'h41, 5'd3, 1'b0};
    tbl[7]  = '{8'd3,  1'b1, 8'h43, 1'b0, 1'b0,
                1'b1, 8'h41, 5'd3, 1'b0};
    tbl[8]  = '{8'd1,  1'b1, 8'h43, 1'b1, 1'b0,
                1'b1, 8'h42, 5'd2, 1'b0};
    tbl[9]  = '{8'd1,  1'b1, 8'h43, 1'b1, 1'b0,
                1'b1, 8'h43, 5'd1, 1'b0};
    tbl[10] = '{8'd1,  1'b1, 8'h43, 1'b1, 1'b0,
                1'b0, 8'h00, 5'd0, 1'b0};
    tbl[11] = '{8'd2,  1'b1, 8'h43, 1'b1, 1'b0,
                1'b0, 8'h00, 5'd0, 1'b0};
    tbl[12] = '{8'd1,  1'b0, 8'h55, 1'b1, 1'b0,
                1'b0, 8'h00, 5'd0, 1'b0};
    tbl[13] = '{8'd1,  1'b1, 8'h55, 1'b1, 1'b0,
                1'b1, 8'h55, 5'd1, 1'b0};
    tbl[14] = '{8'd1,  1'b1, 8'h55, 1'b1, 1'b0,
                1'b0, 8'h00, 5'd0, 1'b0};
    tbl[15] = '{8'd4,  1'b1, 8'h66, 1'b0, 1'b1,
                1'b0, 8'h00, 5'd0, 1'b0};

    arstn         = 1'b0;
    rx_data_valid = 1'b1;
    rx_data       = 8'h00;
    s_if.m_ready  = 1'b0;
    clr_ovf       = 1'b0;
    @(posedge clk);
    #1;
    chk_state("reset", 1'b0, 8'h00, 0, 1'b0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    chk("reset.af", int'(almost_full), 0);
`endif
    @(posedge clk);
    #1;
    arstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        step(tbl[i].dv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      end
      chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed,
                int'(tbl[i].ec), tbl[i].eo);
    end

    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), 1'b0);
    end
    chk_state("fill16", 1'b1, 8'h00, 16, 1'b0);
    push_byte(8'h10, 1'b0);
    chk_state("drop17", 1'b1, 8'h00, 16, 1'b1);
    step(1'b0, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("set_wins.ovf", int'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain17.data", int'(s_if.m_data), i);
      step(1'b1, 8'h00, 1'b1, 1'b0);
    end
    chk_state("drain17.end", 1'b0, 8'h00, 0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);

    for (int i = 0; i < 16; i++) begin
      push_byte(8'(8'h50 + i), 1'b0);
    end
    step(1'b0, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk_state("full_pp", 1'b1, 8'h51, 16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("full_pp.drain", int'(s_if.m_data),
          (i < 15) ? (8'h51 + i) : 8'hAA);
      step(1'b1, 8'h00, 1'b1, 1'b0);
    end
    chk_state("full_pp.end", 1'b0, 8'h00, 0, 1'b0);

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 11; i++) begin
      push_byte(8'(i), 1'b0);
    end
    chk("af11", int'(almost_full), 0);
    push_byte(8'd11, 1'b0);
    chk("af12", int'(almost_full), 1);
    chk("af12.count", int'(count), 12);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("af_pop", int'(almost_full), 0);
    chk("af_pop.count", int'(count), 11);
    push_byte(8'h20, 1'b0);
    push_byte(8'h21, 1'b0);
    chk("af13", int'(almost_full), 1);
`else
    for (int i = 0; i < 3; i++) begin
      push_byte(8'(8'h30 + i), 1'b0);
    end
    chk("pre_rst.count", int'(count), 3);
`endif
    step(1'b0, 8'h22, 1'b0, 1'b0);
    #2;
    arstn = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 8'h00, 0, 1'b0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    chk("async_rst.af", int'(almost_full), 0);
`endif
    rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    arstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h22, 1'b0, 1'b0);
    end
    chk_state("post_rst", 1'b0, 8'h00, 0, 1'b0);
    push_byte(8'h99, 1'b0);
    chk_state("post_rst.push", 1'b1, 8'h99, 1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("post_rst.pop", int'(count), 0);

    got = 0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      logic dv;
      logic rdy;
      dv  = (cyc / 2 < 40) ? logic'(cyc % 2) : 1'b1;
      rdy = logic'(cyc % 2 == 0);
      if (s_if.m_valid && rdy) begin
        chk("wrap.order", int'(s_if.m_data), got);
        got++;
      end
      step(dv, 8'(cyc / 2), rdy, 1'b0);
    end
    chk("wrap.total", got, 40);
    chk("wrap.ovf", int'(overflow), 0);
    chk("wrap.count", int'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Detects each completed byte from the receiver's `data_valid` level and stores `data` in a circular FIFO.
- Presents bytes to the system side over a valid/ready stream.
- Provides an occupancy count and a sticky overflow flag, so software and logic can tolerate bursty consumers without losing characters silently.

Parameters:
- W_DATA, 8, byte width; must match the receiver's W_DATA.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- AF_LEVEL, DEPTH-4, almost-full threshold (used only with the optional feature).

Ports:
- clk  in  1  system clock, the same clock as the receiver.
- arstn  in  1  asynchronous, active-low reset.
- rx_data_valid  in  1  receiver byte-done level; high while the receiver is idle, low while a frame is in progress.
- rx_data  in  W_DATA  receiver data; stable while rx_data_valid is high.
- m_valid  out  1  FIFO head byte available.
- m_data  out  W_DATA  FIFO head byte.
- m_ready  in  1  consumer accepts the head byte.
- count  out  $clog2(DEPTH)+1  current number of stored bytes.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of overflow.
- almost_full  out  1  present only with UART_RX_FIFO_ALMOST_FULL_EN.

Behaviour:
- Reset (arstn low, asynchronous):
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - m_valid = 0, m_data = 0, overflow = 0.
  - Edge register vld_d = 1, so that the receiver's reset-high level produces no push.
- Push detect:
  - push = rx_data_valid & ~vld_d.
  - vld_d <= rx_data_valid every cycle.
  - Exactly one push per rising edge; a level held high never re-pushes.
- Write:
  - On a clock edge with push and count < DEPTH: mem[wr_ptr] <= rx_data, wr_ptr <= wr_ptr+1.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Read:
  - pop = m_valid & m_ready.
  - On pop: rd_ptr <= rd_ptr+1.
- Output timing:
  - First-word fall-through: m_data = mem[rd_ptr] (combinational from the array, registered pointer).
  - m_valid = (count != 0).
  - Latency from push edge to m_valid high is 1 cycle.
- Count update:
  - +1 on accepted push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Full with simultaneous pop:
  - If count == DEPTH and push and pop occur in the same cycle, the push is accepted (the slot freed by the pop is reused).
  - count stays DEPTH; overflow is not set.
- Full without pop:
  - If count == DEPTH and push occurs without a pop, the byte is dropped and the pointers are unchanged.
  - overflow <= 1 on the next edge.
- overflow:
  - Stays set until clr_ovf is sampled high.
  - If clr_ovf and a new drop happen in the same cycle, set wins (overflow stays 1).
- Empty:
  - m_ready while empty has no effect; pointers are unchanged.
  - A push into an empty FIFO with m_ready high is not popped in the same cycle; it appears on m_valid the next cycle.
- Stability: m_data and m_valid must not change while m_valid=1 and m_ready=0, except that m_valid stays 1.
- Reset mid-operation: all stored bytes are discarded and the state returns to the reset values immediately. The first push after reset requires a fresh low-to-high transition on rx_data_valid.
- No combinational path from rx_data_valid or rx_data to any output.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- With the macro defined:
  - Adds the almost_full port.
  - almost_full is registered: almost_full = (count >= AF_LEVEL), updated in the same cycle as count.
  - Reset value 0.
  - Intended to drive RTS-style flow control.
- Without the macro: the port and its logic are absent; AF_LEVEL is ignored.

Test Plan:
1. Reset release with rx_data_valid held 1 for 20 cycles -> no push; count=0, m_valid=0, overflow=0.
2. Three frames 0x41, 0x42, 0x43 (rx_data_valid low 10 cycles, then high with data), m_ready=0:
   - count = 1, 2, 3, each 1 cycle after its rising edge.
   - m_data=0x41 stable.
   - Then m_ready=1 for 3 cycles -> m_data reads 0x41, 0x42, 0x43 in order; count=0, m_valid=0.
3. DEPTH=16, m_ready=0, push 0x00..0x10 (17 bytes):
   - count=16.
   - overflow=1 after the 17th edge.
   - Drain yields 0x00..0x0F; 0x10 is absent.
   - Pulse clr_ovf -> overflow=0.
4. FIFO full (count=16), push 0xAA in the same cycle as a pop:
   - overflow stays 0, count stays 16.
   - Draining shows 0xAA as the last byte.
5. Wrap-around: 40 bytes 0x00..0x27 pushed with m_ready toggling 1-of-2 cycles -> all 40 bytes are received in order with no drops; pointers wrap at least twice.
6. With UART_RX_FIFO_ALMOST_FULL_EN, AF_LEVEL=12:
   - almost_full rises on the edge where count becomes 12.
   - It falls when a pop takes count to 11.
   - Assert arstn low mid-burst -> count=0, m_valid=0, almost_full=0 asynchronously.
